bus_protocol_master: RTL and testbench

BUS_PROTOCOL_MASTER -- requirements
Module: bus_protocol_master

---
 rtl/bus_protocol_master_if.sv | 61 ++++++
 rtl/bus_protocol_master.sv | 224 ++++++++++++++++++++++
 tb/tb_bus_protocol_master.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_protocol_master_if.sv
// -----------------------------------------------------------------------------
// bus_protocol_master_if
//
// Purpose:
//   Bundles the upstream byte handshake and the downstream data bus of
//   bus_protocol_master into one port, so the master and the environment that
//   feeds and acknowledges it share a single connection.
//
// Parameters:
//   DEPTH     - FIFO depth of the attached master; sets the width of level.
//
// Signals:
//   in_valid  - upstream byte offered                     (into master)
//   in_data   - upstream byte                             (into master)
//   in_ready  - master FIFO can accept a byte             (from master)
//   dValid    - bus data valid, registered                (from master)
//   data      - bus data, registered                      (from master)
//   dAck      - target acceptance, sampled on posedge     (into master)
//   err       - one-cycle pulse on protocol error or drop (from master)
//   level     - current FIFO occupancy                    (from master)
//
// Modports:
//   master    - the bus_protocol_master side
//   slave     - the upstream source / bus target side
// -----------------------------------------------------------------------------
interface bus_protocol_master_if #(
    parameter int DEPTH = 4
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               dValid;
    logic [7:0]         data;
    logic               dAck;
    logic               err;
    logic [LEVEL_W-1:0] level;

    modport master (
        input  in_valid,
        input  in_data,
        input  dAck,
        output in_ready,
        output dValid,
        output data,
        output err,
        output level
    );

    modport slave (
        output in_valid,
        output in_data,
        output dAck,
        input  in_ready,
        input  dValid,
        input  data,
        input  err,
        input  level
    );
endinterface

// File: rtl/bus_protocol_master.sv
// -----------------------------------------------------------------------------
// bus_protocol_master
//
// Purpose:
//   Accepts bytes from an upstream valid/ready source into a small FIFO and
//   presents them one at a time on a registered dValid/data bus. A transfer
//   lasts 2..4 cycles: the target acknowledges with dAck from the second beat
//   on. An acknowledge on the first beat is flagged with err and otherwise
//   ignored. With no acknowledge by the fourth beat the transfer times out and
//   the same byte is re-presented after a one-cycle gap; once MAX_RETRY retries
//   have also timed out the byte is dropped and err pulses. Every transfer is
//   followed by exactly one idle bus cycle.
//
// Parameters:
//   DEPTH     - FIFO depth in bytes (power of 2, >= 2)
//   MAX_RETRY - retries after a timed-out transfer before the byte is dropped
//
// Ports:
//   clk       - single clock, all state updates on posedge
//   reset     - asynchronous, active-high reset
//   bus       - bus_protocol_master_if.master:
//                 in_valid/in_data/in_ready  upstream byte handshake
//                 dValid/data/dAck           downstream bus
//                 err                        protocol error / drop pulse
//                 level                      FIFO occupancy
// -----------------------------------------------------------------------------
module bus_protocol_master #(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_protocol_master_if.master bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    // Wide enough to hold 0..MAX_RETRY, and at least one bit when MAX_RETRY=0.
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    // Beat numbers within one transfer (cnt counts dValid-high cycles).
    localparam logic [2:0] BEAT_FIRST   = 3'd1;
    localparam logic [2:0] BEAT_MIN_ACK = 3'd2;
    localparam logic [2:0] BEAT_LAST    = 3'd4;

    // Bus state machine encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q,  level_d;

    logic [1:0]         state_q,  state_d;
    logic [2:0]         cnt_q,    cnt_d;
    logic [RETRY_W-1:0] retry_q,  retry_d;
    logic               dvalid_q, dvalid_d;
    logic [7:0]         data_q,   data_d;
    logic               err_q,    err_d;

    logic               in_ready;
    logic               push;
    logic               pop;

    // -------------------------------------------------------------------------
    // Upstream handshake
    // -------------------------------------------------------------------------
    assign in_ready = (level_q != LEVEL_FULL);
    assign push     = bus.in_valid && in_ready;

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; emptiness is tracked solely by
    // level_q and the pointers, so stale bytes are never observable and the
    // array can map onto plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Pointer and occupancy update. A push and a pop in the same cycle leave
    // level unchanged. Pops only happen from XFER, where the byte on the bus is
    // still held in the FIFO, so level is never zero when pop is set.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus state machine
    // -------------------------------------------------------------------------
    // The head byte stays in the FIFO for the whole transfer and is only popped
    // on completion or on a final drop. A retry therefore re-reads the very
    // same entry, and pushes landing behind it never touch data_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        dvalid_d = dvalid_q;
        data_d   = data_q;
        err_d    = 1'b0;
        pop      = 1'b0;

        case (state_q)
            // GAP has the same exit conditions as IDLE; being in GAP already
            // guarantees the single idle bus cycle after a transfer.
            ST_IDLE, ST_GAP: begin
                if (level_q != '0) begin
                    state_d  = ST_XFER;
                    dvalid_d = 1'b1;
                    data_d   = mem_q[rd_ptr_q];
                    cnt_d    = BEAT_FIRST;
                end else begin
                    state_d  = ST_IDLE;
                    dvalid_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            ST_XFER: begin
                if (bus.dAck && (cnt_q >= BEAT_MIN_ACK)) begin
                    // Valid acknowledge: transfer complete.
                    state_d  = ST_GAP;
                    dvalid_d = 1'b0;
                    cnt_d    = '0;
                    retry_d  = '0;
                    pop      = 1'b1;
                end else if (cnt_q == BEAT_LAST) begin
                    // Timeout. Ack has priority above, so a dAck on the last
                    // beat still completes the transfer.
                    state_d  = ST_GAP;
                    dvalid_d = 1'b0;
                    cnt_d    = '0;
                    if (retry_q == RETRY_LAST) begin
                        pop     = 1'b1;
                        err_d   = 1'b1;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    // Keep presenting; an ack on the first beat is too early.
                    cnt_d = cnt_q + 3'd1;
                    if (bus.dAck && (cnt_q == BEAT_FIRST)) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                dvalid_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register, regardless
    // of the order the statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            dvalid_q <= 1'b0;
            data_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            dvalid_q <= dvalid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready = in_ready;
    assign bus.dValid   = dvalid_q;
    assign bus.data     = data_q;
    assign bus.err      = err_q;
    assign bus.level    = level_q;

endmodule

// File: tb/tb_bus_protocol_master.sv
// -----------------------------------------------------------------------------
// tb_bus_protocol_master
//
// Purpose:
//   Self-checking bench for bus_protocol_master (DEPTH=4, MAX_RETRY=2).
//   Directed scenarios with hand-computed expectations, plus a long run with
//   random dAck timing against a byte-order scoreboard. A bus monitor records
//   every dValid run (length, data, gap before it) and counts protocol
//   violations: run shorter than 2 or longer than 4, data changing while
//   valid, valid still high after a valid ack, or a fall that is neither an
//   ack completion nor a 4-beat timeout.
// -----------------------------------------------------------------------------
module tb_bus_protocol_master;

    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 2;
    localparam int N_RANDOM  = 1000;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    bus_protocol_master_if #(.DEPTH(DEPTH)) bus ();

    bus_protocol_master #(
        .DEPTH     (DEPTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bus monitor (samples mid-cycle on negedge)
    // -------------------------------------------------------------------------
    int         mon_run      = 0;
    int         mon_gap      = 0;
    logic       mon_prev_ack = 1'b0;
    logic       mon_had_prev = 1'b0;
    logic [7:0] mon_data     = 8'h00;
    int         viol_cnt     = 0;
    int         err_cnt      = 0;
    int         run_q[$];
    int         gap_q[$];
    logic [7:0] data_q[$];

    always @(negedge clk) begin
        if (reset) begin
            mon_run      = 0;
            mon_gap      = 0;
            mon_prev_ack = 1'b0;
            mon_had_prev = 1'b0;
        end else begin
            if (bus.dValid) begin
                if (mon_run == 0) begin
                    mon_data = bus.data;
                    if (mon_had_prev) gap_q.push_back(mon_gap);
                end else if (bus.data !== mon_data) begin
                    viol_cnt++;
                end
                if (mon_prev_ack) viol_cnt++;
                mon_run++;
                if (mon_run > 4) viol_cnt++;
                mon_prev_ack = bus.dAck && (mon_run >= 2);
            end else begin
                if (mon_run > 0) begin
                    run_q.push_back(mon_run);
                    data_q.push_back(mon_data);
                    if (!mon_prev_ack && mon_run != 4) viol_cnt++;
                    mon_had_prev = 1'b1;
                    mon_gap      = 0;
                end
                mon_gap++;
                mon_run      = 0;
                mon_prev_ack = 1'b0;
            end
            if (bus.err === 1'b1) err_cnt++;
        end
    end

    // -------------------------------------------------------------------------
    // Helpers (stimulus and formatting only)
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive dAck for the current cycle, then advance one clock.
    task automatic step(input logic ack);
        bus.dAck = ack;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.dAck     = 1'b0;
        reset        = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic clear_mon();
        run_q.delete();
        gap_q.delete();
        data_q.delete();
        mon_had_prev = 1'b0;
    endtask

    function automatic string int_list(input int q[$]);
        string s = "";
        for (int i = 0; i < q.size(); i++) begin
            if (i != 0) s = {s, " "};
            s = {s, $sformatf("%0d", q[i])};
        end
        return s;
    endfunction

    function automatic string hex_list(input logic [7:0] q[$]);
        string s = "";
        for (int i = 0; i < q.size(); i++) begin
            if (i != 0) s = {s, " "};
            s = {s, $sformatf("%02h", q[i])};
        end
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.dAck     = 1'b0;
        reset        = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.dValid !== 1'b0)   $display("FAIL reset_dValid: got %b want 0", bus.dValid); else n_pass++;
        n_checks++; if (bus.data !== 8'h00)    $display("FAIL reset_data: got %h want 00", bus.data); else n_pass++;
        n_checks++; if (bus.err !== 1'b0)      $display("FAIL reset_err: got %b want 0", bus.err); else n_pass++;
        n_checks++; if (bus.level !== 3'd0)    $display("FAIL reset_level: got %0d want 0", bus.level); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        tick();
        n_checks++; if (bus.level !== 3'd0)    $display("FAIL reset_no_push: got level %0d want 0", bus.level); else n_pass++;
    endtask

    task automatic test_single();
        int e0;
        do_reset();
        clear_mon();
        e0 = err_cnt;
        push_byte(8'hA5);
        n_checks++; if (bus.level !== 3'd1)  $display("FAIL single_level_push: got %0d want 1", bus.level); else n_pass++;
        n_checks++; if (bus.dValid !== 1'b0) $display("FAIL single_no_early_rise: got %b want 0", bus.dValid); else n_pass++;
        step(1'b0);
        n_checks++; if (bus.dValid !== 1'b1 || bus.data !== 8'hA5) $display("FAIL single_beat1: got v=%b d=%h want v=1 d=a5", bus.dValid, bus.data); else n_pass++;
        step(1'b0);
        n_checks++; if (bus.dValid !== 1'b1 || bus.data !== 8'hA5) $display("FAIL single_beat2: got v=%b d=%h want v=1 d=a5", bus.dValid, bus.data); else n_pass++;
        step(1'b1);
        n_checks++; if (bus.dValid !== 1'b0) $display("FAIL single_fall_after_ack: got %b want 0", bus.dValid); else n_pass++;
        n_checks++; if (bus.level !== 3'd0)  $display("FAIL single_level_pop: got %0d want 0", bus.level); else n_pass++;
        repeat (3) step(1'b0);
        n_checks++; if (int_list(run_q) != "2")  $display("FAIL single_runs: got '%s' want '2'", int_list(run_q)); else n_pass++;
        n_checks++; if (hex_list(data_q) != "a5") $display("FAIL single_data: got '%s' want 'a5'", hex_list(data_q)); else n_pass++;
        n_checks++; if (err_cnt - e0 != 0) $display("FAIL single_err: got %0d pulses want 0", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_timeout();
        int e0;
        do_reset();
        clear_mon();
        e0 = err_cnt;
        push_byte(8'h3C);
        // Rise after edge 2; three 4-beat attempts separated by 1-cycle gaps
        // end with the drop at edge 16 (15 steps after the push).
        repeat (14) step(1'b0);
        n_checks++; if (bus.dValid !== 1'b1 || bus.data !== 8'h3C || bus.level !== 3'd1)
            $display("FAIL timeout_last_beat: got v=%b d=%h lvl=%0d want v=1 d=3c lvl=1", bus.dValid, bus.data, bus.level); else n_pass++;
        step(1'b0);
        n_checks++; if (bus.err !== 1'b1)    $display("FAIL timeout_err_pulse: got %b want 1", bus.err); else n_pass++;
        n_checks++; if (bus.level !== 3'd0 || bus.dValid !== 1'b0)
            $display("FAIL timeout_drop: got lvl=%0d v=%b want lvl=0 v=0", bus.level, bus.dValid); else n_pass++;
        step(1'b0);
        n_checks++; if (bus.err !== 1'b0 || bus.dValid !== 1'b0)
            $display("FAIL timeout_after_drop: got err=%b v=%b want 0 0", bus.err, bus.dValid); else n_pass++;
        repeat (3) step(1'b0);
        n_checks++; if (int_list(run_q) != "4 4 4") $display("FAIL timeout_runs: got '%s' want '4 4 4'", int_list(run_q)); else n_pass++;
        n_checks++; if (int_list(gap_q) != "1 1")   $display("FAIL timeout_gaps: got '%s' want '1 1'", int_list(gap_q)); else n_pass++;
        n_checks++; if (hex_list(data_q) != "3c 3c 3c") $display("FAIL timeout_retry_data: got '%s' want '3c 3c 3c'", hex_list(data_q)); else n_pass++;
        n_checks++; if (err_cnt - e0 != 1) $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_early_ack();
        int e0;
        do_reset();
        clear_mon();
        e0 = err_cnt;
        push_byte(8'h11);
        step(1'b0);
        step(1'b1);
        n_checks++; if (bus.err !== 1'b1 || bus.dValid !== 1'b1 || bus.data !== 8'h11)
            $display("FAIL early_err_pulse: got err=%b v=%b d=%h want 1 1 11", bus.err, bus.dValid, bus.data); else n_pass++;
        step(1'b0);
        n_checks++; if (bus.err !== 1'b0 || bus.dValid !== 1'b1)
            $display("FAIL early_beat3: got err=%b v=%b want 0 1", bus.err, bus.dValid); else n_pass++;
        step(1'b1);
        n_checks++; if (bus.dValid !== 1'b0 || bus.level !== 3'd0)
            $display("FAIL early_complete: got v=%b lvl=%0d want 0 0", bus.dValid, bus.level); else n_pass++;
        repeat (3) step(1'b0);
        n_checks++; if (int_list(run_q) != "3") $display("FAIL early_runs: got '%s' want '3'", int_list(run_q)); else n_pass++;
        n_checks++; if (err_cnt - e0 != 1) $display("FAIL early_err_count: got %0d want 1", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e0;
        int beat;
        int done;
        int cyc;
        do_reset();
        clear_mon();
        e0 = err_cnt;
        bus.dAck = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            tick();
        end
        n_checks++; if (bus.level !== 3'd4)    $display("FAIL b2b_full_level: got %0d want 4", bus.level); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready_full: got %b want 0", bus.in_ready); else n_pass++;
        bus.in_data = 8'h05;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.level !== 3'd4)    $display("FAIL b2b_fifth_ignored: got level %0d want 4", bus.level); else n_pass++;
        n_checks++; if (bus.dValid !== 1'b1 || bus.data !== 8'h01)
            $display("FAIL b2b_head_on_bus: got v=%b d=%h want 1 01", bus.dValid, bus.data); else n_pass++;
        // First attempt saw no ack and times out; then ack every byte on beat 2.
        step(1'b0);
        n_checks++; if (bus.dValid !== 1'b0)   $display("FAIL b2b_first_timeout: got %b want 0", bus.dValid); else n_pass++;
        beat = 0;
        done = 0;
        cyc  = 0;
        while (done < 4 && cyc < 100) begin
            if (bus.dValid) beat++; else beat = 0;
            step(beat == 2);
            if (beat == 2) begin
                done++;
                beat = 0;
            end
            cyc++;
        end
        n_checks++; if (done != 4) $display("FAIL b2b_timeout: got %0d completions want 4", done); else n_pass++;
        repeat (3) step(1'b0);
        n_checks++; if (int_list(run_q) != "4 2 2 2 2") $display("FAIL b2b_runs: got '%s' want '4 2 2 2 2'", int_list(run_q)); else n_pass++;
        n_checks++; if (int_list(gap_q) != "1 1 1 1")   $display("FAIL b2b_gaps: got '%s' want '1 1 1 1'", int_list(gap_q)); else n_pass++;
        n_checks++; if (hex_list(data_q) != "01 01 02 03 04") $display("FAIL b2b_order: got '%s' want '01 01 02 03 04'", hex_list(data_q)); else n_pass++;
        n_checks++; if (bus.level !== 3'd0 || bus.in_ready !== 1'b1)
            $display("FAIL b2b_drained: got lvl=%0d rdy=%b want 0 1", bus.level, bus.in_ready); else n_pass++;
        n_checks++; if (err_cnt - e0 != 0) $display("FAIL b2b_err: got %0d pulses want 0", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int e0;
        do_reset();
        clear_mon();
        e0 = err_cnt;
        bus.dAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA1 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (bus.dValid !== 1'b1 || bus.level !== 3'd3)
            $display("FAIL rstmid_setup: got v=%b lvl=%0d want 1 3", bus.dValid, bus.level); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.dValid !== 1'b0)   $display("FAIL rstmid_dValid_async: got %b want 0", bus.dValid); else n_pass++;
        n_checks++; if (bus.level !== 3'd0)    $display("FAIL rstmid_level: got %0d want 0", bus.level); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.err !== 1'b0)      $display("FAIL rstmid_err: got %b want 0", bus.err); else n_pass++;
        reset = 1'b0;
        repeat (4) step(1'b0);
        n_checks++; if (bus.dValid !== 1'b0 || bus.level !== 3'd0)
            $display("FAIL rstmid_discarded: got v=%b lvl=%0d want 0 0", bus.dValid, bus.level); else n_pass++;
        n_checks++; if (err_cnt - e0 != 0) $display("FAIL rstmid_err_count: got %0d want 0", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] model_q[$];
        logic [7:0] byte_drv;
        int         attempts;
        int         beat;
        int         pushed;
        int         bad;
        int         delivered;
        int         dropped;
        int         exp_err;
        int         cyc;
        int         e0;
        logic       v;
        logic       ack;
        logic       accept;
        do_reset();
        clear_mon();
        e0        = err_cnt;
        attempts  = 0;
        beat      = 0;
        pushed    = 0;
        bad       = 0;
        delivered = 0;
        dropped   = 0;
        exp_err   = 0;
        cyc       = 0;
        while ((pushed < N_RANDOM || model_q.size() != 0 || bus.dValid) && cyc < 30000) begin
            v = bus.dValid;
            if (v) beat++; else beat = 0;
            if (v && beat == 1) begin
                if (model_q.size() == 0) bad++;
                else if (bus.data !== model_q[0]) bad++;
            end
            byte_drv = 8'(pushed * 7 + 3);
            bus.in_data  = byte_drv;
            bus.in_valid = (pushed < N_RANDOM) && ($urandom_range(0, 1) == 1);
            accept = bus.in_valid && bus.in_ready;
            ack    = ($urandom_range(0, 2) == 0);
            step(ack);
            if (accept) begin
                model_q.push_back(byte_drv);
                pushed++;
            end
            if (v) begin
                if (ack && beat >= 2) begin
                    delivered++;
                    void'(model_q.pop_front());
                    attempts = 0;
                    beat     = 0;
                end else if (beat == 4) begin
                    attempts++;
                    beat = 0;
                    if (attempts > MAX_RETRY) begin
                        dropped++;
                        exp_err++;
                        void'(model_q.pop_front());
                        attempts = 0;
                    end
                end else if (ack && beat == 1) begin
                    exp_err++;
                end
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        repeat (3) step(1'b0);
        n_checks++; if (cyc >= 30000) $display("FAIL rand_timeout: ran %0d cycles, pushed %0d, queued %0d", cyc, pushed, model_q.size()); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL rand_data: got %0d wrong bytes want 0", bad); else n_pass++;
        n_checks++; if (delivered + dropped != N_RANDOM)
            $display("FAIL rand_accounting: got %0d delivered + %0d dropped want %0d", delivered, dropped, N_RANDOM); else n_pass++;
        n_checks++; if (err_cnt - e0 != exp_err) $display("FAIL rand_err_count: got %0d want %0d", err_cnt - e0, exp_err); else n_pass++;
        n_checks++; if (viol_cnt != 0) $display("FAIL rand_protocol: got %0d violations want 0", viol_cnt); else n_pass++;
        n_checks++; if (bus.level !== 3'd0) $display("FAIL rand_level_end: got %0d want 0", bus.level); else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.dAck     = 1'b0;
        test_reset();
        test_single();
        test_timeout();
        test_early_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
